mod_addsub_pipe: RTL and testbench

- Two-stage pipelined modular adder/subtractor for the radix-16 butterfly datapath.
- Operands are split into 3-bit carry-lookahead groups. Each group produces a sum plus group generate/propagate.
- A second-level lookahead unit consumes the group generate/propagate terms to form group carries.
- A registered correction stage reduces the result into [0, MODULUS).

---
 rtl/ntt_arith_pkg.sv | 17 +
 rtl/cla_group_carry.sv | 35 +++
 rtl/cla_group_slice.sv | 34 +++
 rtl/mod_addsub_pipe.sv | 111 +++++++++++
 tb/tb_mod_addsub_pipe.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/ntt_arith_pkg.sv
// Shared arithmetic definitions for the NTT butterfly datapath.
package ntt_arith_pkg;

   // Width of one carry-lookahead group. The group-slice cell is built for this width.
   localparam int CLA_GRP_W = 3;

   // Default datapath configuration: 15-bit operands, five lookahead groups.
   localparam int                   DEF_WIDTH   = 15;
   localparam logic [DEF_WIDTH-1:0] DEF_MODULUS = 15'd12289;

   // Operation select carried alongside each operand pair.
   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

endpackage

// File: rtl/cla_group_carry.sv
// Second-level carry lookahead over NGRP groups.
// Each c[k+1] is built as a flat sum of products of the G, P and cin terms.
// No group carry waits on the carry of the group below it.
module cla_group_carry #(
   parameter int NGRP = 5
) (
   input  logic [NGRP-1:0] g,
   input  logic [NGRP-1:0] p,
   input  logic            cin,
   output logic [NGRP:1]   c
);

   // Carry out of group k:
   //   G[k] | P[k]G[k-1] | ... | P[k..1]G[0] | P[k..0]cin
   function automatic logic la_carry(input logic [NGRP-1:0] gv,
                                     input logic [NGRP-1:0] pv,
                                     input logic            c0,
                                     input int              k);
      logic acc;
      logic term;
      acc = c0;
      for (int m = 0; m <= k; m++) acc = acc & pv[m];
      for (int j = 0; j <= k; j++) begin
         term = gv[j];
         for (int m = j + 1; m <= k; m++) term = term & pv[m];
         acc = acc | term;
      end
      return acc;
   endfunction

   for (genvar k = 0; k < NGRP; k++) begin : g_carry
      assign c[k+1] = la_carry(g, p, cin, k);
   end

endmodule

// File: rtl/cla_group_slice.sv
// 3-bit carry-lookahead group: local sum plus group generate/propagate.
// The group carry-in only affects the sum bits. G and P are independent of
// it, which lets the second-level lookahead run in parallel with the groups.
module cla_group_slice
   import ntt_arith_pkg::*;
(
   input  logic [CLA_GRP_W-1:0] a,
   input  logic [CLA_GRP_W-1:0] b,
   input  logic                 cin,
   output logic [CLA_GRP_W-1:0] sum,
   output logic                 grp_g,
   output logic                 grp_p
);

   logic [CLA_GRP_W-1:0] bit_g;
   logic [CLA_GRP_W-1:0] bit_p;
   logic [CLA_GRP_W-1:0] bit_c;

   assign bit_g = a & b;
   assign bit_p = a ^ b;

   // Flattened in-group carries, sum bits, and group generate/propagate.
   // NOTE: every output of an always_comb block gets an assignment on every
   // path. A missed path here would infer a latch instead of logic.
   always_comb begin
      bit_c[0] = cin;
      bit_c[1] = bit_g[0] | (bit_p[0] & cin);
      bit_c[2] = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & cin);
      sum      = bit_p ^ bit_c;
      grp_g    = bit_g[2] | (bit_p[2] & bit_g[1]) | (bit_p[2] & bit_p[1] & bit_g[0]);
      grp_p    = &bit_p;
   end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular adder/subtractor for the radix-16 butterfly.
// Stage 0 forms a +/- b as a two-level carry-lookahead sum (WIDTH+1 bits).
// Stage 1 registers it. Stage 2 folds the result back into [0, MODULUS)
// and registers the output.
module mod_addsub_pipe
   import ntt_arith_pkg::*;
#(
   parameter int               WIDTH   = DEF_WIDTH,
   parameter logic [WIDTH-1:0] MODULUS = DEF_MODULUS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   input  logic             mode_sub,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   localparam int NGRP = WIDTH / CLA_GRP_W;

   // ---------------- Stage 0: lookahead adder ----------------
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;
   logic [NGRP-1:0]  grp_g;
   logic [NGRP-1:0]  grp_p;
   logic [NGRP:1]    grp_c;
   logic [NGRP:0]    carry;
   logic [WIDTH:0]   raw;

   // Subtraction is a + ~b + 1. The +1 enters as the carry into group 0.
   assign b_eff        = (mode_sub == MODE_SUB) ? ~b_in : b_in;
   assign carry[0]     = mode_sub;
   assign carry[NGRP:1] = grp_c;

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      cla_group_slice u_slice (
         .a     (a_in [k*CLA_GRP_W +: CLA_GRP_W]),
         .b     (b_eff[k*CLA_GRP_W +: CLA_GRP_W]),
         .cin   (carry[k]),
         .sum   (sum  [k*CLA_GRP_W +: CLA_GRP_W]),
         .grp_g (grp_g[k]),
         .grp_p (grp_p[k])
      );
   end

   cla_group_carry #(
      .NGRP (NGRP)
   ) u_carry (
      .g   (grp_g),
      .p   (grp_p),
      .cin (mode_sub),
      .c   (grp_c)
   );

   assign raw = {carry[NGRP], sum};

   // ---------------- Stage 1 register ----------------
   logic [WIDTH:0] s1_raw;
   mode_e          s1_sub;
   logic           s1_v;

   // Capture the raw sum with its mode and valid tag on every enabled cycle.
   // NOTE: sequential state uses non-blocking assignments only. All registers
   // then update together from pre-edge values, whatever the statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_raw <= '0;
         s1_sub <= MODE_ADD;
         s1_v   <= 1'b0;
      end else if (en) begin
         // NOTE: the data fields load on every enabled cycle, valid or not.
         // Only s1_v qualifies them, so a bubble costs no extra enable logic.
         s1_raw <= raw;
         s1_sub <= mode_e'(mode_sub);
         s1_v   <= in_valid;
      end
   end

   // ---------------- Stage 2: modular correction ----------------
   logic [WIDTH:0]   mod_ext;
   logic [WIDTH-1:0] corr;

   assign mod_ext = {1'b0, MODULUS};

   // Fold the raw sum into [0, MODULUS).
   // Add: raw is at most 2M-2, so one conditional subtract is enough.
   // Sub: no carry out means a < b, so add M back (truncated to WIDTH).
   always_comb begin
      corr = s1_raw[WIDTH-1:0];
      if (s1_sub == MODE_SUB) begin
         if (!s1_raw[WIDTH]) corr = s1_raw[WIDTH-1:0] + MODULUS;
      end else if (s1_raw >= mod_ext) begin
         corr = WIDTH'(s1_raw - mod_ext);
      end
   end

   // Output register: corrected result and its valid tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (en) begin
         out_valid <= s1_v;
         out_data  <= corr;
      end
   end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe: directed literals plus a
// scoreboard model checked on every cycle.
module tb_mod_addsub_pipe;

   localparam int          W = 15;
   localparam int unsigned M = 12289;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         in_valid;
   logic         mode_sub;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         out_valid;
   logic [W-1:0] out_data;

   int pass_cnt  = 0;
   int total_cnt = 0;

   mod_addsub_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .mode_sub  (mode_sub),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Mathematical result of the modular operation.
   function automatic int unsigned ref_result(input int unsigned a, input int unsigned b,
                                              input logic sub);
      if (sub) return (a >= b) ? (a - b) : (a + M - b);
      return (a + b) % M;
   endfunction

   // ---------------- Scoreboard model ----------------
   // Each enabled edge accepts one slot, valid or bubble. A slot appears at
   // the output one enabled edge after the one that follows its acceptance.
   typedef struct {
      bit          v;
      int unsigned d;
   } slot_t;

   slot_t       q[$];
   bit          exp_v   = 1'b0;
   int unsigned exp_d   = 0;
   bit          armed   = 1'b0;
   bit          fresh   = 1'b0;
   int          n_valid = 0;

   always @(posedge clk) begin
      slot_t s;
      fresh = 1'b0;
      if (rst) begin
         q.delete();
         exp_v = 1'b0;
         exp_d = 0;
         armed = 1'b1;
      end else if (en) begin
         fresh = 1'b1;
         s.v = in_valid;
         s.d = ref_result(a_in, b_in, mode_sub);
         q.push_back(s);
         if (q.size() > 1) begin
            s     = q.pop_front();
            exp_v = s.v;
            exp_d = s.d;
         end
      end
   end

   // Compare the DUT against the model on every cycle after the first reset.
   always @(negedge clk) begin
      if (armed) begin
         check("out_valid", out_valid, exp_v);
         if (exp_v) check("out_data", out_data, exp_d);
         if (fresh && out_valid) n_valid++;
      end
   end

   // Present one operation, then check its literal result two edges later.
   task automatic directed(input int unsigned a, input int unsigned b, input logic sub,
                           input int unsigned exp, input string name);
      @(negedge clk);
      in_valid = 1'b1; mode_sub = sub; a_in = W'(a); b_in = W'(b);
      @(negedge clk);
      in_valid = 1'b0;
      check({name, "_lat1_valid"}, out_valid, 0);
      @(negedge clk);
      check({name, "_valid"}, out_valid, 1);
      check({name, "_data"}, out_data, exp);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; in_valid = 1'b0; mode_sub = 1'b0; a_in = '0; b_in = '0;
      repeat (2) @(negedge clk);
      check("reset_valid", out_valid, 0);
      check("reset_data", out_data, 0);
      rst = 1'b0;

      directed(12288, 1,     1'b0, 0,     "add_wrap");
      directed(6000,  7000,  1'b0, 711,   "add_reduce");
      directed(100,   200,   1'b0, 300,   "add_plain");
      directed(0,     0,     1'b0, 0,     "add_zero");
      directed(5,     7,     1'b1, 12287, "sub_under");
      directed(0,     12288, 1'b1, 1,     "sub_0_mmax");
      directed(7,     5,     1'b1, 2,     "sub_plain");
      directed(4321,  4321,  1'b1, 0,     "sub_equal");
      directed(12288, 12288, 1'b0, 12287, "add_max");

      // Back-to-back random stream with a 3-cycle stall in the middle.
      @(negedge clk);
      n_valid = 0;
      for (int i = 0; i < 64; i++) begin
         if (i != 0) @(negedge clk);
         in_valid = 1'b1;
         mode_sub = 1'($urandom_range(0, 1));
         a_in     = W'($urandom_range(0, M - 1));
         b_in     = W'($urandom_range(0, M - 1));
         if (i == 30) begin
            en = 1'b0;
            repeat (3) @(negedge clk);
            en = 1'b1;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("stream_count", n_valid, 64);

      // Reset with two operations in flight.
      in_valid = 1'b1; mode_sub = 1'b0; a_in = W'(10); b_in = W'(20);
      @(negedge clk);
      a_in = W'(30); b_in = W'(40);
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("midrst_valid", out_valid, 0);
      check("midrst_data", out_data, 0);
      rst = 1'b0;
      n_valid = 0;
      repeat (4) @(negedge clk);
      check("midrst_no_stale", n_valid, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
